// File: rtl/mem_req_master_if.sv
// Command, memory-port and response signals of mem_req_master, grouped for port connection.
interface mem_req_master_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_rnw_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic              req_o;
  logic              req_rnw_o;
  logic [ADDR_W-1:0] req_addr_o;
  logic [DATA_W-1:0] req_wdata_o;
  logic              req_ready_i;
  logic [DATA_W-1:0] req_rdata_i;
  logic              rsp_valid_o;
  logic              rsp_rnw_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;

  modport master (
    input  cmd_valid_i, cmd_rnw_i, cmd_addr_i, cmd_wdata_i, req_ready_i, req_rdata_i,
    output cmd_ready_o, req_o, req_rnw_o, req_addr_o, req_wdata_o,
           rsp_valid_o, rsp_rnw_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    output cmd_valid_i, cmd_rnw_i, cmd_addr_i, cmd_wdata_i, req_ready_i, req_rdata_i,
    input  cmd_ready_o, req_o, req_rnw_o, req_addr_o, req_wdata_o,
           rsp_valid_o, rsp_rnw_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/mem_req_master.sv
// Buffers commands in a FIFO and issues them one at a time on a level req/ready memory port.
// Latency: req rises 2 edges after accept into an idle block; response registered on the completing edge.
// Backpressure: cmd_ready_o = FIFO not full, responses unthrottled; MEM_REQ_TIMEOUT_EN adds a wait abort.
module mem_req_master #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  mem_req_master_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic              rnw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t            state, state_nxt;
  cmd_t              fifo_mem [DEPTH];
  cmd_t              head;
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              full, empty, push, pop, done_ok, done_abort;
  logic              rsp_valid, rsp_rnw;
  logic [DATA_W-1:0] rsp_rdata;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign empty   = (wr_ptr == rd_ptr);
  assign push    = bus.cmd_valid_i && !full;
  assign head    = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign done_ok = (state == REQ) && bus.req_ready_i;
  assign pop     = done_ok || done_abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr[PTR_W-1:0]] <= {bus.cmd_rnw_i, bus.cmd_addr_i, bus.cmd_wdata_i};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // GAP drops req for one cycle so the memory re-arms its delay.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!empty) state_nxt = REQ;
      REQ:     if (pop) state_nxt = GAP;
      GAP:     state_nxt = empty ? IDLE : REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready_o = !full;
    bus.req_o       = (state == REQ);
    bus.req_rnw_o   = head.rnw;
    bus.req_addr_o  = head.addr;
    bus.req_wdata_o = head.wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rnw   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= pop;
      if (pop) begin
        rsp_rnw   <= head.rnw;
        rsp_rdata <= (done_ok && head.rnw) ? bus.req_rdata_i : '0;
      end
    end
  end

  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_rnw_o   = rsp_rnw;
  assign bus.rsp_rdata_o = rsp_rdata;

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             rsp_err;

  assign done_abort = (state == REQ) && !bus.req_ready_i && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Held at zero outside REQ, so every REQ entry starts a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                wait_cnt <= '0;
    else if (state != REQ || bus.req_ready_i) wait_cnt <= '0;
    else                                      wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    rsp_err <= 1'b0;
    else if (pop) rsp_err <= done_abort;
  end

  assign bus.rsp_err_o = rsp_err;
`else
  assign done_abort    = 1'b0;
  assign bus.rsp_err_o = 1'b0;
`endif
endmodule
